pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Parametrised pipeline sequencer/hazard unit for the 5-stage RISC core; supersedes the
//  free-running PC/start scheme. Owns PC generation, a run/drain/done FSM, per-stage valid
//  bits, load-use stall, taken-branch flush, halt drain and a retired-instruction counter.
//  Sits beside the IF/ID, ID/EXE and EXE/MEM buffers and drives their enables/bubbles.
// PARAMETERS
//  IMW      4   PC / instruction-memory address width
//  RFW      5   register-file address width
//  NSTAGE   5   pipeline depth (>=5); stage index 0=IF 1=ID 2=EXE 3=MEM, NSTAGE-1=WB
//  CW       32  retired-counter width
//  START_PC 0   PC loaded on reset and on start
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst          in   1       asynchronous, active-high reset
//  start        in   1       begin run; honoured only in IDLE or DONE
//  id_rs1       in   RFW     source reg 1 of instruction in ID
//  id_rs2       in   RFW     source reg 2 of instruction in ID
//  id_use_rs1   in   1       ID instruction reads rs1
//  id_use_rs2   in   1       ID instruction reads rs2
//  id_is_halt   in   1       ID instruction is HALT
//  exe_rd       in   RFW     destination reg of instruction in EXE
//  exe_is_load  in   1       EXE instruction is a load
//  exe_br_taken in   1       EXE instruction is a taken branch
//  exe_br_tgt   in   IMW     branch target
//  pc           out  IMW     fetch address (registered)
//  if_id_en     out  1       IF/ID buffer load enable (comb.)
//  id_exe_bubble out 1       force NOP into ID/EXE (comb.)
//  flush        out  1       kill IF and ID contents (comb.)
//  valid        out  NSTAGE  per-stage valid bits (registered)
//  retired      out  CW      instructions retired since start (registered)
//  busy         out  1       state is RUN or DRAIN
//  done         out  1       state is DONE
// BEHAVIOUR
//  Reset: state=IDLE, pc=START_PC, valid=0, retired=0; comb outputs 0 in IDLE/DONE.
//  Reset mid-run aborts at once; no drain.
//  FSM: IDLE -start-> RUN; RUN -halt accepted-> DRAIN; DRAIN -valid==0-> DONE;
//   DONE -start-> RUN. start in RUN/DRAIN ignored.
//  On start: pc<=START_PC, valid<=0, retired<=0; first fetch valid next cycle.
//  Hazard terms (comb., current cycle):
//   br    = valid[2] & exe_br_taken
//   stall = !br & valid[2] & exe_is_load & exe_rd!=0 & valid[1] &
//           ((id_use_rs1 & id_rs1==exe_rd) | (id_use_rs2 & id_rs2==exe_rd))
//   halt  = !br & !stall & valid[1] & id_is_halt & state==RUN
//  RUN, normal: pc<=pc+1 (mod 2^IMW, wraps silently); valid<={valid[N-2:0],1}.
//  br (priority over all): pc<=exe_br_tgt; flush=1; valid[0],valid[1] <=0 next;
//   valid[2] gets 0 (ID was killed); older stages shift normally.
//  stall: pc held; if_id_en=0; id_exe_bubble=1; valid[1] held, valid[2]<=0;
//   stages >=3 shift. Stall lasts exactly one cycle per load-use pair.
//  halt: state<=DRAIN; fetch disabled (valid[0] input 0, pc held);
//   IF slot behind HALT invalidated; HALT itself proceeds and retires.
//  DRAIN: pipeline shifts with 0 fed at IF; if_id_en=1; to DONE when valid==0.
//  retired: +1 each cycle valid[NSTAGE-1]=1 in RUN/DRAIN; saturates at 2^CW-1.
//  if_id_en=1 in RUN/DRAIN except stall; 0 in IDLE/DONE.
// TESTING
//  1 rst mid-RUN with valid=5'b11111 -> same cycle valid=0, pc=0, busy=0, retired=0.
//  2 start, 6 indep ALU ops + HALT at pc=6 -> DONE after drain, retired=7, pc holds 7.
//  3 load r3 in EXE, ID reads r3 -> one cycle if_id_en=0, id_exe_bubble=1, pc held;
//    same with exe_rd=0 -> no stall.
//  4 taken branch in EXE to 4'hA with load-use also true -> flush=1, no stall,
//    pc=A next, valid[1:0]=0.
//  5 IMW=4, straight-line code from pc=14 -> pc sequence 14,15,0,1.
//  6 CW=3, 9 instructions retired -> retired saturates at 7; start in DRAIN ignored.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer and hazard unit for the 5-stage RISC core.
//
// It generates the PC and runs a run/drain/done FSM. It tracks one valid
// bit per stage, detects load-use stalls, flushes on a taken branch, drains
// the pipe on HALT and counts retired instructions (saturating).
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   start            begin a run (honoured in IDLE or DONE only)
//   id_*             register usage and HALT flag of the instruction in ID
//   exe_*            destination, load flag and branch info of the instruction in EXE
//   pc               fetch address (registered)
//   if_id_en         IF/ID buffer load enable (combinational)
//   id_exe_bubble    force a NOP into ID/EXE (combinational)
//   flush            kill IF and ID contents (combinational)
//   valid            per-stage valid bits, [0]=IF .. [NSTAGE-1]=WB (registered)
//   retired          instructions retired since start (registered, saturating)
//   busy, done       FSM status
//
// State  | meaning
// -------+------------------------------------------------------------
// IDLE   | after reset, waiting for start
// RUN    | fetching and executing
// DRAIN  | HALT accepted, fetch stopped, pipe emptying
// DONE   | pipe empty after HALT, waiting for start
module pipe_ctrl #(
    parameter int IMW    = 4,
    parameter int RFW    = 5,
    parameter int NSTAGE = 5,
    parameter int CW     = 32,
    parameter logic [IMW-1:0] START_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [RFW-1:0]    id_rs1,
    input  logic [RFW-1:0]    id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_is_halt,
    input  logic [RFW-1:0]    exe_rd,
    input  logic              exe_is_load,
    input  logic              exe_br_taken,
    input  logic [IMW-1:0]    exe_br_tgt,
    output logic [IMW-1:0]    pc,
    output logic              if_id_en,
    output logic              id_exe_bubble,
    output logic              flush,
    output logic [NSTAGE-1:0] valid,
    output logic [CW-1:0]     retired,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [IMW-1:0]      pc_nxt;
    logic [NSTAGE-1:0]   valid_nxt;
    logic [CW-1:0]       retired_nxt;
    logic                br, stall, halt, ld_use;

    assign busy = (state == S_RUN) || (state == S_DRAIN);
    assign done = (state == S_DONE);

    assign ld_use = (id_use_rs1 && (id_rs1 == exe_rd)) ||
                    (id_use_rs2 && (id_rs2 == exe_rd));

    // Branch wins over stall, and both win over HALT acceptance.
    assign br    = busy && valid[2] && exe_br_taken;
    assign stall = busy && !br && valid[2] && exe_is_load &&
                   (exe_rd != '0) && valid[1] && ld_use;
    assign halt  = (state == S_RUN) && !br && !stall && valid[1] && id_is_halt;

    assign if_id_en      = busy && !stall;
    assign id_exe_bubble = stall;
    assign flush         = br;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            pc      <= START_PC;
            valid   <= '0;
            retired <= '0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            valid   <= valid_nxt;
            retired <= retired_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        valid_nxt   = valid;
        retired_nxt = retired;

        if (busy && valid[NSTAGE-1] && (retired != {CW{1'b1}}))
            retired_nxt = retired + CW'(1);

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt   = S_RUN;
                    pc_nxt      = START_PC;
                    valid_nxt   = '0;
                    retired_nxt = '0;
                end
            end
            S_RUN: begin
                if (br) begin
                    // IF and ID are killed; the killed ID never reaches EXE.
                    pc_nxt                = exe_br_tgt;
                    valid_nxt[NSTAGE-1:3] = valid[NSTAGE-2:2];
                    valid_nxt[2:0]        = 3'b000;
                end else if (stall) begin
                    // IF and ID hold, a bubble enters EXE, older stages move on.
                    valid_nxt[NSTAGE-1:3] = valid[NSTAGE-2:2];
                    valid_nxt[2]          = 1'b0;
                end else if (halt) begin
                    // HALT moves to EXE; the slot fetched behind it is dropped.
                    state_nxt    = S_DRAIN;
                    valid_nxt    = {valid[NSTAGE-2:0], 1'b0};
                    valid_nxt[1] = 1'b0;
                end else begin
                    // The PC steps only once the IF slot holds a real fetch, so
                    // after start or a redirect the first address is not skipped.
                    valid_nxt = {valid[NSTAGE-2:0], 1'b1};
                    if (valid[0])
                        pc_nxt = pc + IMW'(1);
                end
            end
            S_DRAIN: begin
                valid_nxt = {valid[NSTAGE-2:0], 1'b0};
                if (valid == '0)
                    state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    localparam int IMW = 4;
    localparam int RFW = 5;
    localparam int NS  = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [RFW-1:0] id_rs1, id_rs2, exe_rd;
    logic           id_use_rs1, id_use_rs2, id_is_halt;
    logic           exe_is_load, exe_br_taken;
    logic [IMW-1:0] exe_br_tgt;

    logic [IMW-1:0] pc, pc_s;
    logic           if_id_en, if_id_en_s, id_exe_bubble, id_exe_bubble_s;
    logic           flush, flush_s, busy, busy_s, done, done_s;
    logic [NS-1:0]  valid, valid_s;
    logic [31:0]    retired;
    logic [2:0]     retired_s;

    pipe_ctrl #(.IMW(IMW), .RFW(RFW), .NSTAGE(NS), .CW(32)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_is_halt(id_is_halt), .exe_rd(exe_rd), .exe_is_load(exe_is_load),
        .exe_br_taken(exe_br_taken), .exe_br_tgt(exe_br_tgt),
        .pc(pc), .if_id_en(if_id_en), .id_exe_bubble(id_exe_bubble), .flush(flush),
        .valid(valid), .retired(retired), .busy(busy), .done(done)
    );

    pipe_ctrl #(.IMW(IMW), .RFW(RFW), .NSTAGE(NS), .CW(3)) u_sat (
        .clk(clk), .rst(rst), .start(start),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_is_halt(id_is_halt), .exe_rd(exe_rd), .exe_is_load(exe_is_load),
        .exe_br_taken(exe_br_taken), .exe_br_tgt(exe_br_tgt),
        .pc(pc_s), .if_id_en(if_id_en_s), .id_exe_bubble(id_exe_bubble_s), .flush(flush_s),
        .valid(valid_s), .retired(retired_s), .busy(busy_s), .done(done_s)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] got);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", got, ~got);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, got, e.val);
        end
    endtask

    task automatic clear_inputs();
        start        = 1'b0;
        id_rs1       = '0;
        id_rs2       = '0;
        id_use_rs1   = 1'b0;
        id_use_rs2   = 1'b0;
        id_is_halt   = 1'b0;
        exe_rd       = '0;
        exe_is_load  = 1'b0;
        exe_br_taken = 1'b0;
        exe_br_tgt   = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) until both ID and EXE hold valid instructions.
    task automatic wait_ready(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (valid[2] && valid[1]) ok = 1'b1;
            else @(negedge clk);
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_pc(input string tag, input logic [IMW-1:0] target, input int vbit);
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (pc == target && valid[vbit]) ok = 1'b1;
            else @(negedge clk);
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    // Straight-line program of halt_pc ALU ops followed by HALT at address halt_pc.
    // HALT sits in ID when pc == halt_pc + 1.
    task automatic run_program(input logic [IMW-1:0] halt_pc, input int exp_ret, input int exp_sat);
        bit ok = 1'b0;
        pulse_start();
        check("start_busy", 32'(busy), 32'd1);
        check("start_pc", 32'(pc), 32'd0);
        check("start_valid", 32'(valid), 32'd0);
        sb_push("done_retired", exp_ret);
        sb_push("done_retired_sat", exp_sat);
        sb_push("done_pc", 32'(halt_pc + 4'd1));
        wait_pc("halt_reach_timeout", halt_pc + 4'd1, 1);
        id_is_halt = 1'b1;
        #1;
        check("halt_if_id_en", 32'(if_id_en), 32'd1);
        @(negedge clk);
        id_is_halt = 1'b0;
        check("drain_valid", 32'(valid), 32'b11100);
        check("drain_busy", 32'(busy), 32'd1);
        pulse_start();
        check("drain_start_ign_pc", 32'(pc), 32'(halt_pc + 4'd1));
        check("drain_start_ign_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 20 && !ok; i++) begin
            if (done) ok = 1'b1;
            else @(negedge clk);
        end
        check("done_timeout", 32'(ok), 32'd1);
        sb_pop(retired);
        sb_pop(32'(retired_s));
        sb_pop(32'(pc));
        check("done_valid", 32'(valid), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        check("done_if_id_en", 32'(if_id_en), 32'd0);
    endtask

    typedef struct {
        logic           use1, use2, load;
        logic [RFW-1:0] rs1, rs2, rd;
        logic           stall;
    } hz_t;

    hz_t hz_tab[$];

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [IMW-1:0] p;
        hz_t h;

        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_if_id_en", 32'(if_id_en), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_flush", 32'(flush), 32'd0);

        run_program(4'd6, 7, 7);
        check("done_flag", 32'(done), 32'd1);
        run_program(4'd8, 9, 7);

        // Load-use hazards.
        hz_tab.push_back('{1'b1, 1'b0, 1'b1, 5'd3, 5'd0, 5'd3, 1'b1});
        hz_tab.push_back('{1'b0, 1'b1, 1'b1, 5'd1, 5'd7, 5'd7, 1'b1});
        hz_tab.push_back('{1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0});
        hz_tab.push_back('{1'b1, 1'b1, 1'b1, 5'd2, 5'd4, 5'd6, 1'b0});
        hz_tab.push_back('{1'b1, 1'b0, 1'b0, 5'd3, 5'd0, 5'd3, 1'b0});
        pulse_start();
        foreach (hz_tab[k]) begin
            h = hz_tab[k];
            wait_ready("hz_ready_timeout");
            id_use_rs1  = h.use1;
            id_use_rs2  = h.use2;
            exe_is_load = h.load;
            id_rs1      = h.rs1;
            id_rs2      = h.rs2;
            exe_rd      = h.rd;
            #1;
            check("hz_if_id_en", 32'(if_id_en), 32'(!h.stall));
            check("hz_bubble", 32'(id_exe_bubble), 32'(h.stall));
            p = pc;
            sb_push("hz_pc_next", 32'(h.stall ? p : p + 4'd1));
            sb_push("hz_valid2", 32'(!h.stall));
            @(negedge clk);
            clear_inputs();
            sb_pop(32'(pc));
            sb_pop(32'(valid[2]));
            if (h.stall) begin
                check("stall_one_cycle_bubble", 32'(id_exe_bubble), 32'd0);
                @(negedge clk);
                check("stall_release_pc", 32'(pc), 32'(p + 4'd1));
            end
        end

        // Taken branch with a simultaneous load-use match: branch wins.
        wait_ready("br_ready_timeout");
        exe_br_taken = 1'b1;
        exe_br_tgt   = 4'hA;
        exe_is_load  = 1'b1;
        exe_rd       = 5'd3;
        id_rs1       = 5'd3;
        id_use_rs1   = 1'b1;
        #1;
        check("br_flush", 32'(flush), 32'd1);
        check("br_no_bubble", 32'(id_exe_bubble), 32'd0);
        check("br_if_id_en", 32'(if_id_en), 32'd1);
        sb_push("br_pc", 32'hA);
        sb_push("br_valid_lo", 32'd0);
        @(negedge clk);
        clear_inputs();
        sb_pop(32'(pc));
        sb_pop(32'(valid[2:0]));

        // PC wrap from 14.
        wait_pc("wrap_timeout", 4'd14, 0);
        sb_push("wrap_pc0", 32'd15);
        sb_push("wrap_pc1", 32'd0);
        sb_push("wrap_pc2", 32'd1);
        repeat (3) begin
            @(negedge clk);
            sb_pop(32'(pc));
        end

        // Asynchronous reset in the middle of a full pipe.
        check("pre_rst_valid", 32'(valid), 32'b11111);
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(valid), 32'd0);
        check("arst_pc", 32'(pc), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_retired", retired, 32'd0);
        check("arst_retired_sat", 32'(retired_s), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_if_id_en", 32'(if_id_en), 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
